// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit adder: one 4-bit carry-lookahead slice per stage, with the
// inter-nibble carry registered and valid/ready flow control through every stage.

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s    = a & b;
  assign p_s    = a ^ b;
  assign c_s[0] = ci;
  assign c_s[1] = g_s[0] | (p_s[0] & ci);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & ci);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);
  assign s      = p_s ^ c_s[3:0];
  assign co     = c_s[4];

endmodule

module cla_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int S = WIDTH / 4;

  logic [S-1:0]     v_r;
  logic [S-1:0]     c_r;
  logic [WIDTH-1:0] psum_r [S];
  logic [WIDTH-1:0] arem_r [S];
  logic [WIDTH-1:0] brem_r [S];

  logic [S:0]       rdy_s;
  logic [WIDTH-1:0] ain_s  [S];
  logic [WIDTH-1:0] bin_s  [S];
  logic [WIDTH-1:0] pin_s  [S];
  logic [S-1:0]     cin_s;
  logic [S-1:0]     vin_s;
  logic [S-1:0]     co_s;
  logic [3:0]       nib_s  [S];

  // Ready chain: an empty stage accepts even when everything downstream is stalled
  always_comb begin
    rdy_s    = {(S+1){1'b0}};
    rdy_s[S] = out_ready;
    for (int j = S - 1; j >= 0; j--) begin
      rdy_s[j] = ~v_r[j] | rdy_s[j+1];
    end
  end

  // Stage inputs: stage 0 sees the ports, later stages see the previous stage's registers
  always_comb begin
    ain_s[0] = a;
    bin_s[0] = b;
    pin_s[0] = {WIDTH{1'b0}};
    cin_s    = {S{1'b0}};
    vin_s    = {S{1'b0}};
    cin_s[0] = cin;
    vin_s[0] = in_valid;
    for (int j = 1; j < S; j++) begin
      ain_s[j] = arem_r[j-1];
      bin_s[j] = brem_r[j-1];
      pin_s[j] = psum_r[j-1];
      cin_s[j] = c_r[j-1];
      vin_s[j] = v_r[j-1];
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_slice
    cla_4bit u_cla (
      .a  (ain_s[k][3:0]),
      .b  (bin_s[k][3:0]),
      .ci (cin_s[k]),
      .s  (nib_s[k]),
      .co (co_s[k])
    );
  end

  // Stage registers; operands shift down a nibble per stage, data only loads with a valid beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r <= {S{1'b0}};
      c_r <= {S{1'b0}};
      for (int j = 0; j < S; j++) begin
        psum_r[j] <= {WIDTH{1'b0}};
        arem_r[j] <= {WIDTH{1'b0}};
        brem_r[j] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int j = 0; j < S; j++) begin
        if (rdy_s[j]) begin
          v_r[j] <= vin_s[j];
          if (vin_s[j]) begin
            psum_r[j] <= pin_s[j] | ({{(WIDTH-4){1'b0}}, nib_s[j]} << (4 * j));
            arem_r[j] <= {4'd0, ain_s[j][WIDTH-1:4]};
            brem_r[j] <= {4'd0, bin_s[j][WIDTH-1:4]};
            c_r[j]    <= co_s[j];
          end
        end
      end
    end
  end

  assign in_ready  = rst_n & rdy_s[0];
  assign out_valid = v_r[S-1];
  assign sum       = psum_r[S-1];
  assign cout      = c_r[S-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: scoreboard of a+b+cin plus directed
// latency, backpressure and mid-flight reset scenarios.

module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  logic [16:0] sb_q [$];
  int out_cyc_q [$];

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: compare/pop on output transfer, check held result under stall, push on input transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc_q.push_back(cyc);
        if (sb_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else chk("result", {15'd0, cout, sum}, {15'd0, sb_q.pop_front()});
      end else if (out_valid) begin
        if (sb_q.size() == 0) chk("spurious_held", 32'(out_valid), 32'd0);
        else chk("held", {15'd0, cout, sum}, {15'd0, sb_q[0]});
      end
      if (in_valid && in_ready) begin
        n_acc++;
        sb_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1; holds the beat until the block accepts it
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    int n;
    n = 0;
    a = aa;
    b = bb;
    cin = cc;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int base_acc;
    int base_out;

    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'h1234;
    b = 16'h4321;
    cin = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Single beat latency
    step();
    send(16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("single_sum", {15'd0, cout, sum}, 32'h0000_5555);
    @(negedge clk);
    chk("single_drop", 32'(out_valid), 32'd0);

    // Carry ripple through every stage
    step();
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h0FF0, 16'h0010, 1'b0);
    drain("carry_drain");

    // Back-to-back streaming
    step();
    out_cyc_q.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(16'(i) * 16'h1111, 16'h0101, 1'(i & 1));
    drain("stream_drain");
    chk("stream_count", 32'(out_cyc_q.size()), 32'd8);
    if (out_cyc_q.size() > 0) chk("stream_first_lat", 32'(out_cyc_q[0] - t0), 32'd4);
    for (int j = 1; j < out_cyc_q.size(); j++)
      chk("stream_consec", 32'(out_cyc_q[j] - out_cyc_q[0]), 32'(j));

    // Backpressure: fill under stall, then drain with out_ready toggling
    step();
    out_ready = 1'b0;
    base_acc = n_acc;
    base_out = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'hF000 + 16'(i) * 16'h0123, 16'h1F0F, 1'(i & 1));
      end
      begin
        int k;
        k = 0;
        repeat (10) @(negedge clk);
        chk("bp_accepted", 32'(n_acc - base_acc), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        step();
        while ((n_out - base_out) < 6 && k < 100) begin
          out_ready = ~out_ready;
          step();
          k++;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_out_count", 32'(n_out - base_out), 32'd6);

    // Reset with three beats in flight
    step();
    base_out = n_out;
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h4444, 1'b1);
    send(16'h5555, 16'h6666, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_out", 32'(n_out - base_out), 32'd0);
    step();
    send(16'h0003, 16'h0005, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_lat_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd1);
    chk("mid_rst_sum", {15'd0, cout, sum}, 32'h0000_0008);
    drain("mid_rst_drain");
    chk("mid_rst_out_count", 32'(n_out - base_out), 32'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
